// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder family: the nibble
// width, the nibble type and the generate/propagate pair used by cla_4b
// and by the wider adders that chain it.
package cla_pkg;

    localparam int CLA_WIDTH = 4;

    typedef logic [CLA_WIDTH-1:0] cla_nibble_t;

    // Per-bit generate and propagate vectors for one nibble.
    typedef struct packed {
        cla_nibble_t g;
        cla_nibble_t p;
    } cla_pg_t;

    // Bit-level generate/propagate terms for an operand pair.
    function automatic cla_pg_t cla_bit_pg(input cla_nibble_t a, input cla_nibble_t b);
        cla_pg_t r;
        r.g = a & b;
        r.p = a ^ b;
        return r;
    endfunction

endpackage

// File: rtl/cla_lookahead_unit.sv
// Combinational 4-bit lookahead unit. Every carry is written as a flat
// sum of products of g/p and c_in so that no carry depends on another
// carry; the same unit serves at the group level of wider adders.
module cla_lookahead_unit
    import cla_pkg::*;
(
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       c_in,
    output logic [4:1] c,
    output logic       gg,
    output logic       gp
);

    // Flattened carry equations and group generate/propagate.
    always_comb begin
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_in);
        gp   = p[3] & p[2] & p[1] & p[0];
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/cla_4b.sv
// Registered 4-bit carry-lookahead adder. Inputs are sampled every rising
// edge and all outputs appear one cycle later; there is no handshake, a
// new operand set is accepted every cycle. Reset is asynchronous and
// active-low and clears every output register.
// Optional feature: define CLA_4B_OVERFLOW_EN to add the registered
// two's-complement overflow output ovf (= c3 ^ c4).
module cla_4b
    import cla_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out,
    output logic       gg,
    output logic       gp
`ifdef CLA_4B_OVERFLOW_EN
    ,
    output logic       ovf
`endif
);

    cla_pg_t     pg;
    logic [4:1]  c;
    logic        gg_next;
    logic        gp_next;
    cla_nibble_t s_next;

    // Bit-level generate/propagate terms.
    always_comb begin
        pg = cla_bit_pg(a, b);
    end

    cla_lookahead_unit u_lookahead (
        .g    (pg.g),
        .p    (pg.p),
        .c_in (c_in),
        .c    (c),
        .gg   (gg_next),
        .gp   (gp_next)
    );

    // Sum bits: propagate XOR the carry into each bit.
    always_comb begin
        s_next = pg.p ^ {c[3:1], c_in};
    end

    // Output registers, cleared asynchronously so nothing is undefined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s     <= '0;
            c_out <= 1'b0;
            gg    <= 1'b0;
            gp    <= 1'b0;
        end else begin
            s     <= s_next;
            c_out <= c[4];
            gg    <= gg_next;
            gp    <= gp_next;
        end
    end

`ifdef CLA_4B_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= c[3] ^ c[4];
        end
    end
`endif

endmodule

// File: tb/tb_cla_4b.sv
// Testbench for cla_4b: directed test-plan vectors, exhaustive sweep,
// random stream and reset checks, scored against an arithmetic model.
module tb_cla_4b;

    localparam int W = 8; // {ovf, gg, gp, c_out, s[3:0]}

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] s;
    logic       c_out;
    logic       gg;
    logic       gp;
    logic       ovf_obs;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    cla_4b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .s     (s),
        .c_out (c_out),
        .gg    (gg),
        .gp    (gp)
`ifdef CLA_4B_OVERFLOW_EN
        ,
        .ovf   (ovf_obs)
`endif
    );

`ifndef CLA_4B_OVERFLOW_EN
    assign ovf_obs = 1'b0;
`endif

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from plain arithmetic.
    function automatic logic [W-1:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
        int          ua;
        int          ub;
        int          sum;
        int          sa;
        int          sb;
        int          sv;
        logic        m_gg;
        logic        m_gp;
        logic        m_ovf;
        logic [4:0]  sum5;
        ua   = int'(ma);
        ub   = int'(mb);
        sum  = ua + ub + int'(mc);
        sum5 = sum[4:0];
        m_gg = (ua + ub) >= 16;      // carry out even without c_in
        m_gp = (ua + ub) == 15;      // carry in would pass straight through
        sa   = ma[3] ? ua - 16 : ua;
        sb   = mb[3] ? ub - 16 : ub;
        sv   = sa + sb + int'(mc);
`ifdef CLA_4B_OVERFLOW_EN
        m_ovf = (sv > 7) || (sv < -8);
`else
        m_ovf = 1'b0;
`endif
        return {m_ovf, m_gg, m_gp, sum5[4], sum5[3:0]};
    endfunction

    function automatic logic [W-1:0] observed();
        return {ovf_obs, gg, gp, c_out, s};
    endfunction

    // Scoreboard check of one registered result.
    task automatic check_out(input string tag, input logic tc);
        logic [W-1:0] exp_v;
        logic [W-1:0] obs_v;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, observed());
            return;
        end
        exp_v = exp_q.pop_front();
        obs_v = observed();
        assert (obs_v === exp_v)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs_v, exp_v);
        end
        checks++;
        assert (c_out === (gg | (gp & tc)))
        else begin
            failures++;
            $error("FAIL %s_identity: c_out=%b expected gg|gp&c_in=%b", tag, c_out, gg | (gp & tc));
        end
    endtask

    // Driver: one vector per cycle, checked one edge later.
    task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
        @(negedge clk);
        a    = ta;
        b    = tb_;
        c_in = tc;
        exp_q.push_back(model(ta, tb_, tc));
        @(posedge clk);
        #1;
        check_out(tag, tc);
    endtask

    task automatic check_zero(input string tag);
        logic [W-1:0] obs_v;
        obs_v = observed();
        checks++;
        assert (obs_v === '0)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs_v, {W{1'b0}});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        c_in  = 1'b1;

        // Reset state with all-ones inputs
        #3;
        check_zero("reset_async");
        @(posedge clk);
        #1;
        check_zero("reset_held");

        // Release; first edge registers F+F+1
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(4'hF, 4'hF, 1'b1));
        @(posedge clk);
        #1;
        check_out("release_first", 1'b1);

        // Carry-in 0
        step("ci0_f_0", 4'hF, 4'h0, 1'b0);
        step("ci0_a_5", 4'hA, 4'h5, 1'b0);
        step("ci0_f_f", 4'hF, 4'hF, 1'b0);
        // Carry-in 1
        step("ci1_f_0", 4'hF, 4'h0, 1'b1);
        step("ci1_0_f", 4'h0, 4'hF, 1'b1);
        step("ci1_5_a", 4'h5, 4'hA, 1'b1);
        step("ci1_f_f", 4'hF, 4'hF, 1'b1);
`ifdef CLA_4B_OVERFLOW_EN
        step("ovf_7_1", 4'h7, 4'h1, 1'b0);
        step("ovf_8_8", 4'h8, 4'h8, 1'b0);
        step("ovf_3_1", 4'h3, 4'h1, 1'b0);
`endif

        // Exhaustive, back to back
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step("exhaustive", v[8:5], v[4:1], v[0]);
        end

        // Random stream
        for (int i = 0; i < 200; i++) begin
            step("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a stream discards the in-flight result
        @(negedge clk);
        a    = 4'hF;
        b    = 4'hF;
        c_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_midstream");
        @(posedge clk);
        #1;
        check_zero("reset_midstream_held");
        @(negedge clk);
        rst_n = 1'b1;
        a     = 4'h7;
        b     = 4'h9;
        c_in  = 1'b1;
        exp_q.push_back(model(4'h7, 4'h9, 1'b1));
        @(posedge clk);
        #1;
        check_out("release_second", 1'b1);

        checks++;
        assert (exp_q.size() == 0)
        else begin
            failures++;
            $error("FAIL scoreboard_drain: leftover=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
